diff_stage_issuer: RTL and testbench
====================================

// Module: diff_stage_issuer
// PURPOSE
//  Backprop sequencer on the producer side of the diff->decode pipeline register.
//  - Walks layers from last to first and the rows of each layer from first to last.
//  - Fetches predict_value and z for each row from the activation buffer.
//  - Presents each row to the register inputs as is_cost_layer/predict_value/z/
//    w_layer_index/w_row_index, with a valid/ready handshake for downstream stall.
// PARAMETERS
//  size       3   elements per row vector
//  data_size  16  bits per element
// PORTS
//  clk                 in   1              system clock, rising edge
//  rst_n               in   1              async active-low reset
//  start               in   1              1-cycle pulse, begins a backprop pass
//  num_layers          in   32             layer count for the pass, sampled on accepted start
//  rc_layer_index      out  32             row-count lookup address
//  rc_row_count        in   32             rows in rc_layer_index, combinational same-cycle
//  act_rd_en           out  1              activation read strobe
//  act_layer_index     out  32             activation read layer
//  act_row_index       out  32             activation read row
//  act_predict_value   in   data_size*size  read data, valid 1 cycle after act_rd_en
//  act_z               in   data_size*size  read data, valid 1 cycle after act_rd_en
//  out_valid           out  1              issue bus holds a row
//  out_ready           in   1              downstream accepts
//  is_cost_layer       out  1              row belongs to layer num_layers-1
//  predict_value       out  data_size*size
//  z                   out  data_size*size
//  w_layer_index       out  32
//  w_row_index         out  32
//  busy                out  1              high from accepted start until done
//  done                out  1              1-cycle pulse at end of pass
//  stall_cycles        out  32             see CONFIGURATION
// BEHAVIOUR
//  Clocking and reset
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset forces state IDLE and drives every output to 0.
//  - Reset mid-pass aborts the pass. No done pulse is produced.
//  State machine
//  - IDLE: waits for start.
//    - start with num_layers==0 -> DONE.
//    - start otherwise -> SIZE, with layer=num_layers-1 and row=0.
//    - start while not IDLE is ignored.
//  - SIZE: rc_layer_index=layer. Latch rc_row_count.
//    - If the count is 0 and layer==0 -> DONE.
//    - If the count is 0 and layer>0 -> SIZE for layer-1.
//    - Otherwise -> FETCH.
//  - FETCH: act_rd_en=1 for exactly 1 cycle with act_layer_index/act_row_index = layer/row -> WAIT.
//  - WAIT: capture act_* data into the hold register. Set out_valid=1 -> EMIT.
//  - EMIT: hold all out_* stable while out_valid && !out_ready. On out_valid && out_ready:
//    - clear out_valid;
//    - if row<count-1: row++ -> FETCH;
//    - else if layer>0: layer--, row=0 -> SIZE;
//    - else -> DONE.
//  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
//  Timing and widths
//  - Throughput with ready held high: 1 row per 3 cycles (FETCH, WAIT, EMIT).
//  - Latency: first out_valid occurs 4 cycles after the start cycle.
//  - is_cost_layer = (layer == num_layers_latched-1). Layer and row counters are 32-bit unsigned.
//  - The layer counter never decrements past 0; termination is detected by a layer==0 compare.
//  - busy goes high the cycle after an accepted start. It stays high through EMIT of the last row.
// CONFIGURATION
//  - `ISSUER_PERF_CNT_EN defined: stall_cycles counts cycles with out_valid && !out_ready.
//    - Clears on accepted start. Saturates at 32'hFFFF_FFFF.
//  - `ISSUER_PERF_CNT_EN undefined: stall_cycles is tied to 0 and no counter logic is built.
// STRUCTURE
//  - backprop_pkg holds:
//    - issuer_state_t enum {IDLE,SIZE,FETCH,WAIT,EMIT,DONE};
//    - localparam INDEX_W=32.
//  - Sub-module issue_hold_reg (size, data_size): load-enabled holding register for the
//    five issue fields. It is loaded in WAIT and otherwise holds.
// TESTING
//  1. num_layers=2, row counts {1:2, 0:3}, ready=1 -> 5 rows issued, in (layer,row) order
//     (1,0) (1,1) (0,0) (0,1) (0,2). is_cost_layer=1 only on the first two. One done pulse.
//  2. Row (1,0) held with ready=0 for 4 cycles -> all out_* stable for 4 cycles.
//     No act_rd_en during the stall. stall_cycles=4 when the macro is defined.
//  3. num_layers=0 -> done 2 cycles after start. out_valid never asserted. act_rd_en never asserted.
//  4. num_layers=3, layer 1 row count 0 -> no row is issued for layer 1.
//     Rows of layer 2 are followed directly by rows of layer 0.
//  5. rst_n low while in EMIT -> all outputs 0 asynchronously. IDLE after release.
//     A new start runs a clean pass.
//  6. Second start pulse while busy -> ignored. Issued sequence is identical to test 1.

Source files
------------

// File: rtl/backprop_pkg.sv
// ============================================================================
// Module : backprop_pkg
// Brief  : Shared types and constants for the backprop issue sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package backprop_pkg;

    localparam int INDEX_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIZE  = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } issuer_state_t;

endpackage

`default_nettype wire

// File: rtl/issue_hold_reg.sv
// ============================================================================
// Module : issue_hold_reg
// Brief  : Load-enabled holding register for the five issue-bus fields.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_hold_reg
    import backprop_pkg::*;
#(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic                        i_is_cost,
    input  logic [data_size*size-1:0]   i_predict_value,
    input  logic [data_size*size-1:0]   i_z,
    input  logic [INDEX_W-1:0]          i_layer_index,
    input  logic [INDEX_W-1:0]          i_row_index,
    output logic                        o_is_cost,
    output logic [data_size*size-1:0]   o_predict_value,
    output logic [data_size*size-1:0]   o_z,
    output logic [INDEX_W-1:0]          o_layer_index,
    output logic [INDEX_W-1:0]          o_row_index
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_is_cost       <= 1'b0;
            o_predict_value <= '0;
            o_z             <= '0;
            o_layer_index   <= '0;
            o_row_index     <= '0;
        end else if (i_load) begin
            o_is_cost       <= i_is_cost;
            o_predict_value <= i_predict_value;
            o_z             <= i_z;
            o_layer_index   <= i_layer_index;
            o_row_index     <= i_row_index;
        end
    end

endmodule

`default_nettype wire

// File: rtl/diff_stage_issuer.sv
// ============================================================================
// Module : diff_stage_issuer
// Brief  : Walks layers last-to-first and rows first-to-last, fetching each
//          row from the activation buffer and issuing it with valid/ready.
//          Optional stall counter built when ISSUER_PERF_CNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module diff_stage_issuer
    import backprop_pkg::*;
#(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [INDEX_W-1:0]          num_layers,
    output logic [INDEX_W-1:0]          rc_layer_index,
    input  logic [INDEX_W-1:0]          rc_row_count,
    output logic                        act_rd_en,
    output logic [INDEX_W-1:0]          act_layer_index,
    output logic [INDEX_W-1:0]          act_row_index,
    input  logic [data_size*size-1:0]   act_predict_value,
    input  logic [data_size*size-1:0]   act_z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        is_cost_layer,
    output logic [data_size*size-1:0]   predict_value,
    output logic [data_size*size-1:0]   z,
    output logic [INDEX_W-1:0]          w_layer_index,
    output logic [INDEX_W-1:0]          w_row_index,
    output logic                        busy,
    output logic                        done,
    output logic [INDEX_W-1:0]          stall_cycles
);

    issuer_state_t          r_state;
    issuer_state_t          w_next_state;

    logic [INDEX_W-1:0]     r_num_layers;
    logic [INDEX_W-1:0]     r_layer;
    logic [INDEX_W-1:0]     r_row;
    logic [INDEX_W-1:0]     r_count;
    logic                   r_out_valid;
    logic                   r_done;

    logic                   w_start_acc;
    logic                   w_more_rows;
    logic                   w_is_cost;
    logic                   w_handshake;

    assign w_start_acc = start && (r_state == IDLE);
    assign w_handshake = r_out_valid && out_ready;
    // 33-bit compare keeps row+1 from wrapping
    assign w_more_rows = ({1'b0, r_row} + 33'd1) < {1'b0, r_count};
    assign w_is_cost   = (r_layer == (r_num_layers - 1'b1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (num_layers == '0) ? DONE : SIZE;
                end
            end
            SIZE: begin
                if (rc_row_count == '0) begin
                    w_next_state = (r_layer == '0) ? DONE : SIZE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            FETCH:   w_next_state = WAIT;
            WAIT:    w_next_state = EMIT;
            EMIT: begin
                if (w_handshake) begin
                    if (w_more_rows) begin
                        w_next_state = FETCH;
                    end else if (r_layer != '0) begin
                        w_next_state = SIZE;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rc_layer_index  = '0;
        act_rd_en       = 1'b0;
        act_layer_index = '0;
        act_row_index   = '0;
        busy            = 1'b0;
        case (r_state)
            SIZE: begin
                rc_layer_index = r_layer;
                busy           = 1'b1;
            end
            FETCH: begin
                act_rd_en       = 1'b1;
                act_layer_index = r_layer;
                act_row_index   = r_row;
                busy            = 1'b1;
            end
            WAIT:    busy = 1'b1;
            EMIT:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Layer/row walk, row-count latch and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_layers <= '0;
            r_layer      <= '0;
            r_row        <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_layers <= num_layers;
                        r_layer      <= num_layers - 1'b1;
                        r_row        <= '0;
                    end
                end
                SIZE: begin
                    r_count <= rc_row_count;
                    if ((rc_row_count == '0) && (r_layer != '0)) begin
                        r_layer <= r_layer - 1'b1;
                    end
                end
                WAIT: r_out_valid <= 1'b1;
                EMIT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (w_more_rows) begin
                            r_row <= r_row + 1'b1;
                        end else if (r_layer != '0) begin
                            r_layer <= r_layer - 1'b1;
                            r_row   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    issue_hold_reg #(
        .size      (size),
        .data_size (data_size)
    ) u_hold (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_load          (r_state == WAIT),
        .i_is_cost       (w_is_cost),
        .i_predict_value (act_predict_value),
        .i_z             (act_z),
        .i_layer_index   (r_layer),
        .i_row_index     (r_row),
        .o_is_cost       (is_cost_layer),
        .o_predict_value (predict_value),
        .o_z             (z),
        .o_layer_index   (w_layer_index),
        .o_row_index     (w_row_index)
    );

    assign out_valid = r_out_valid;
    assign done      = r_done;

`ifdef ISSUER_PERF_CNT_EN
    logic [INDEX_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
    logic w_unused;
    assign w_unused = w_start_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_diff_stage_issuer.sv
// ============================================================================
// Module : tb_diff_stage_issuer
// Brief  : Scoreboard bench for diff_stage_issuer (ISSUER_PERF_CNT_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_diff_stage_issuer;

    localparam int SZ = 3;
    localparam int DS = 16;
    localparam int DW = SZ * DS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [31:0]    num_layers = '0;
    logic [31:0]    rc_layer_index;
    logic [31:0]    rc_row_count;
    logic           act_rd_en;
    logic [31:0]    act_layer_index;
    logic [31:0]    act_row_index;
    logic [DW-1:0]  act_predict_value = '0;
    logic [DW-1:0]  act_z = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           is_cost_layer;
    logic [DW-1:0]  predict_value;
    logic [DW-1:0]  z;
    logic [31:0]    w_layer_index;
    logic [31:0]    w_row_index;
    logic           busy;
    logic           done;
    logic [31:0]    stall_cycles;

    diff_stage_issuer #(.size(SZ), .data_size(DS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_layers        (num_layers),
        .rc_layer_index    (rc_layer_index),
        .rc_row_count      (rc_row_count),
        .act_rd_en         (act_rd_en),
        .act_layer_index   (act_layer_index),
        .act_row_index     (act_row_index),
        .act_predict_value (act_predict_value),
        .act_z             (act_z),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .is_cost_layer     (is_cost_layer),
        .predict_value     (predict_value),
        .z                 (z),
        .w_layer_index     (w_layer_index),
        .w_row_index       (w_row_index),
        .busy              (busy),
        .done              (done),
        .stall_cycles      (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           cost;
        logic [DW-1:0]  pv;
        logic [DW-1:0]  zz;
        logic [31:0]    l;
        logic [31:0]    r;
    } row_t;

    row_t           q[$];
    logic [31:0]    rc_tbl [0:7];
    int             n_vec = 0;
    int             n_err = 0;
    int             done_cnt = 0;
    int             act_cnt = 0;
    int             valid_cnt = 0;

    assign rc_row_count = rc_tbl[rc_layer_index[2:0]];

    function automatic logic [DW-1:0] pv_of(input logic [31:0] l, input logic [31:0] r);
        logic [15:0] mix;
        mix = 16'hA5A5 ^ (l[15:0] * 16'd8 + r[15:0]);
        return {l[15:0], r[15:0], mix};
    endfunction

    // Activation buffer: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (act_rd_en) begin
            act_predict_value <= pv_of(act_layer_index, act_row_index);
            act_z             <= ~pv_of(act_layer_index, act_row_index);
        end
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pass(input int nl);
        row_t e;
        for (int l = nl - 1; l >= 0; l--) begin
            for (int r = 0; r < int'(rc_tbl[l]); r++) begin
                e.cost = (l == nl - 1);
                e.l    = 32'(l);
                e.r    = 32'(r);
                e.pv   = pv_of(32'(l), 32'(r));
                e.zz   = ~pv_of(32'(l), 32'(r));
                q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        row_t e;
        if (rst_n) begin
            if (done)      done_cnt++;
            if (act_rd_en) act_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk_val("sb_unexpected_row", {w_layer_index, w_row_index}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk_val("row_cost",  64'(is_cost_layer), 64'(e.cost));
                    chk_val("row_layer", 64'(w_layer_index), 64'(e.l));
                    chk_val("row_index", 64'(w_row_index),   64'(e.r));
                    chk_val("row_pv",    64'(predict_value), 64'(e.pv));
                    chk_val("row_z",     64'(z),             64'(e.zz));
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] nl);
        @(posedge clk) #1;
        num_layers = nl;
        start      = 1'b1;
        @(posedge clk) #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) chk_val("done_timeout", 64'd0, 64'd1);
        chk_val("sb_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk_val("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin : main
        int d0, a0, v0, lat;
        logic [DW-1:0] s_pv, s_z;
        logic [31:0]   s_l, s_r;
        logic          s_c;
        logic [31:0]   exp_stall;

        for (int i = 0; i < 8; i++) rc_tbl[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_valid", 64'(out_valid), 64'd0);
        chk_val("rst_busy",  64'(busy),      64'd0);
        chk_val("rst_done",  64'(done),      64'd0);
        chk_val("rst_act",   64'(act_rd_en), 64'd0);
        chk_val("rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        // Test 1: two layers, ready high, latency and busy timing
        rc_tbl[0] = 32'd3;
        rc_tbl[1] = 32'd2;
        out_ready = 1'b1;
        d0 = done_cnt;
        push_pass(2);
        @(posedge clk) #1;
        num_layers = 32'd2;
        start = 1'b1;
        @(negedge clk);
        chk_val("busy_start_cycle", 64'(busy), 64'd0);
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk_val("busy_after_start", 64'(busy), 64'd1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_val("first_valid_latency", 64'(lat), 64'd4);
        wait_done(d0);
        repeat (5) @(negedge clk);
        chk_val("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk_val("t1_idle_busy", 64'(busy), 64'd0);

        // Test 2: stall on row (1,0) for four cycles
        out_ready = 1'b0;
        d0 = done_cnt;
        push_pass(2);
        pulse_start(32'd2);
        wait_valid();
        s_pv = predict_value; s_z = z; s_l = w_layer_index; s_r = w_row_index; s_c = is_cost_layer;
        chk_val("stall_act0", 64'(act_rd_en), 64'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk_val("stall_valid", 64'(out_valid),     64'd1);
            chk_val("stall_pv",    64'(predict_value), 64'(s_pv));
            chk_val("stall_z",     64'(z),             64'(s_z));
            chk_val("stall_lr",    {w_layer_index, w_row_index}, {s_l, s_r});
            chk_val("stall_cost",  64'(is_cost_layer), 64'(s_c));
            chk_val("stall_act",   64'(act_rd_en),     64'd0);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        wait_done(d0);
`ifdef ISSUER_PERF_CNT_EN
        exp_stall = 32'd4;
`else
        exp_stall = 32'd0;
`endif
        chk_val("stall_cycles", 64'(stall_cycles), 64'(exp_stall));

        // Test 3: zero layers
        d0 = done_cnt; a0 = act_cnt; v0 = valid_cnt;
        @(posedge clk) #1;
        num_layers = 32'd0;
        start = 1'b1;
        @(negedge clk);
        chk_val("zero_done_c0", 64'(done), 64'd0);
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk_val("zero_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        chk_val("zero_done_c2", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        chk_val("zero_act",   64'(act_cnt - a0),   64'd0);
        chk_val("zero_valid", 64'(valid_cnt - v0), 64'd0);
        chk_val("zero_pulses", 64'(done_cnt - d0), 64'd1);

        // Test 4: three layers with an empty middle layer
        rc_tbl[0] = 32'd1;
        rc_tbl[1] = 32'd0;
        rc_tbl[2] = 32'd2;
        d0 = done_cnt;
        push_pass(3);
        pulse_start(32'd3);
        wait_done(d0);

        // Test 5: reset while in EMIT, then a clean pass
        rc_tbl[0] = 32'd3;
        rc_tbl[1] = 32'd2;
        out_ready = 1'b0;
        push_pass(2);
        pulse_start(32'd2);
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("arst_valid", 64'(out_valid),     64'd0);
        chk_val("arst_busy",  64'(busy),          64'd0);
        chk_val("arst_pv",    64'(predict_value), 64'd0);
        chk_val("arst_z",     64'(z),             64'd0);
        chk_val("arst_lr",    {w_layer_index, w_row_index}, 64'd0);
        chk_val("arst_cost",  64'(is_cost_layer), 64'd0);
        chk_val("arst_done",  64'(done),          64'd0);
        chk_val("arst_stall", 64'(stall_cycles),  64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk_val("arst_idle_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        push_pass(2);
        pulse_start(32'd2);
        wait_done(d0);

        // Test 6: second start while busy is ignored
        d0 = done_cnt;
        push_pass(2);
        pulse_start(32'd2);
        repeat (3) @(posedge clk);
        #1;
        num_layers = 32'd5;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        wait_done(d0);
        repeat (20) @(negedge clk);
        chk_val("restart_pulses", 64'(done_cnt - d0), 64'd1);
        chk_val("restart_sb",     64'(q.size()),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
